// File: rtl/arp_cache_2way.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : arp_cache_2way
// Description : 2-way set-associative ARP cache (IPv4 -> MAC). One FSM
//               serialises clear sweeps, queries and writes against a single
//               read-before-write set RAM (1-cycle read latency). Per-set LRU
//               bit selects the victim way; existing entries update in place.
// Optional    : define ARP_CACHE_EXPIRY_EN to store a per-way timestamp and
//               age entries out after MAX_AGE ticks of age_tick.
// Ports       : clk, rst (sync, active-high)
//               query_request_*  : IP lookup request (valid/ready)
//               query_response_* : lookup result, held until ready (error=miss)
//               write_request_*  : IP/MAC store request (valid/ready)
//               clear_cache      : invalidate all entries
//               age_tick         : timestamp advance strobe (expiry build only)
// Revision    : 1.0 - initial release
// ============================================================================
module arp_cache_2way #(
  parameter int CACHE_ADDR_WIDTH = 9,
  parameter int AGE_WIDTH        = 8,
  parameter int MAX_AGE          = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        query_request_valid,
  output logic        query_request_ready,
  input  logic [31:0] query_request_ip,
  output logic        query_response_valid,
  input  logic        query_response_ready,
  output logic        query_response_error,
  output logic [47:0] query_response_mac,
  input  logic        write_request_valid,
  output logic        write_request_ready,
  input  logic [31:0] write_request_ip,
  input  logic [47:0] write_request_mac,
  input  logic        clear_cache,
  input  logic        age_tick
);

  localparam int SETS = 1 << CACHE_ADDR_WIDTH;
`ifdef ARP_CACHE_EXPIRY_EN
  localparam int TS_W = AGE_WIDTH;
`else
  localparam int TS_W = 0;
`endif
  // Way layout (MSB first): {valid, ip[31:0], mac[47:0], ts}
  localparam int WAY_W  = 1 + 32 + 48 + TS_W;
  localparam int SET_W  = 2 * WAY_W + 1;
  localparam int V_BIT  = WAY_W - 1;
  localparam int IP_HI  = WAY_W - 2;
  localparam int MAC_HI = WAY_W - 34;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_Q_RD   = 3'd2,
    S_Q_CMP  = 3'd3,
    S_Q_RESP = 3'd4,
    S_W_RD   = 3'd5,
    S_W_CMP  = 3'd6
  } state_t;

  function automatic logic [CACHE_ADDR_WIDTH-1:0] set_index(input logic [31:0] ip);
    logic [15:0] folded;
    folded = ip[15:0] ^ ip[31:16];
    return folded[CACHE_ADDR_WIDTH-1:0];
  endfunction

  state_t                      state_q;
  logic [CACHE_ADDR_WIDTH-1:0] sweep_q;
  logic [CACHE_ADDR_WIDTH-1:0] idx_q;
  logic                        clear_pend_q;
  logic [31:0]                 ip_q;
  logic [47:0]                 mac_q;
  logic                        resp_valid_q;
  logic                        resp_err_q;
  logic [47:0]                 resp_mac_q;
  logic [SET_W-1:0]            rd_q;
  logic [SET_W-1:0]            mem_q [SETS];

  // RAM write port, driven combinationally from the FSM state
  logic                        w_we;
  logic [CACHE_ADDR_WIDTH-1:0] w_waddr;
  logic [SET_W-1:0]            w_wdata;

  // --------------------------------------------------------------------------
  // Decode of the set word read in the previous cycle
  // --------------------------------------------------------------------------
  logic [WAY_W-1:0] w_way0, w_way1, w_new_way;
  logic             w_lru;
  logic             w_match0, w_match1, w_exp0, w_exp1;
  logic             w_hit0, w_hit1, w_free0, w_free1, w_tgt;

  assign w_way0 = rd_q[WAY_W-1:0];
  assign w_way1 = rd_q[2*WAY_W-1:WAY_W];
  assign w_lru  = rd_q[SET_W-1];

  assign w_match0 = w_way0[V_BIT] && (w_way0[IP_HI -: 32] == ip_q);
  assign w_match1 = w_way1[V_BIT] && (w_way1[IP_HI -: 32] == ip_q);

`ifdef ARP_CACHE_EXPIRY_EN
  logic [AGE_WIDTH-1:0] now_q;
  logic [AGE_WIDTH-1:0] w_age0, w_age1;

  // Modular age: entries older than 2^AGE_WIDTH ticks may alias as fresh
  assign w_age0    = now_q - w_way0[AGE_WIDTH-1:0];
  assign w_age1    = now_q - w_way1[AGE_WIDTH-1:0];
  assign w_exp0    = w_way0[V_BIT] && (w_age0 >= AGE_WIDTH'(MAX_AGE));
  assign w_exp1    = w_way1[V_BIT] && (w_age1 >= AGE_WIDTH'(MAX_AGE));
  assign w_new_way = {1'b1, ip_q, mac_q, now_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q <= '0;
    end else if (age_tick) begin
      now_q <= now_q + 1'b1;
    end
  end
`else
  logic w_unused_age;

  assign w_exp0       = 1'b0;
  assign w_exp1       = 1'b0;
  assign w_new_way    = {1'b1, ip_q, mac_q};
  assign w_unused_age = age_tick ^ (AGE_WIDTH == MAX_AGE);
`endif

  assign w_hit0  = w_match0 && !w_exp0;
  assign w_hit1  = w_match1 && !w_exp1;
  assign w_free0 = !w_way0[V_BIT] || w_exp0;
  assign w_free1 = !w_way1[V_BIT] || w_exp1;

  // Write victim: matching way (in-place), then first free/expired, then LRU
  always_comb begin
    w_tgt = w_lru;
    if (w_match0)     w_tgt = 1'b0;
    else if (w_match1) w_tgt = 1'b1;
    else if (w_free0)  w_tgt = 1'b0;
    else if (w_free1)  w_tgt = 1'b1;
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = idx_q;
    w_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = sweep_q;
      end
      S_Q_CMP: begin
        // A hit only refreshes the LRU bit; way 0 wins a double match
        if (w_hit0 || w_hit1) begin
          w_we    = 1'b1;
          w_wdata = {w_hit0, rd_q[2*WAY_W-1:0]};
        end
      end
      S_W_CMP: begin
        w_we    = 1'b1;
        w_wdata = w_tgt ? {1'b0, w_new_way, w_way0}
                        : {1'b1, w_way1, w_new_way};
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Set RAM: one write port, registered read (block-RAM inferrable)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
    rd_q <= mem_q[idx_q];
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      sweep_q      <= '1;
      idx_q        <= '0;
      clear_pend_q <= 1'b0;
      ip_q         <= '0;
      mac_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_mac_q   <= '0;
    end else begin
      // A clear arriving mid-operation waits for the operation to finish
      if (clear_cache && (state_q != S_IDLE) && (state_q != S_CLEAR)) begin
        clear_pend_q <= 1'b1;
      end

      case (state_q)
        S_CLEAR: begin
          sweep_q <= sweep_q - 1'b1;
          if (sweep_q == '0) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clear_cache || clear_pend_q) begin
            state_q      <= S_CLEAR;
            sweep_q      <= '1;
            clear_pend_q <= 1'b0;
          end else if (query_request_valid) begin
            ip_q    <= query_request_ip;
            idx_q   <= set_index(query_request_ip);
            state_q <= S_Q_RD;
          end else if (write_request_valid) begin
            ip_q    <= write_request_ip;
            mac_q   <= write_request_mac;
            idx_q   <= set_index(write_request_ip);
            state_q <= S_W_RD;
          end
        end
        S_Q_RD: begin
          state_q <= S_Q_CMP;
        end
        S_Q_CMP: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= !(w_hit0 || w_hit1);
          resp_mac_q   <= w_hit0 ? w_way0[MAC_HI -: 48] :
                          w_hit1 ? w_way1[MAC_HI -: 48] : 48'h0;
          state_q      <= S_Q_RESP;
        end
        S_Q_RESP: begin
          if (query_response_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_W_RD: begin
          state_q <= S_W_CMP;
        end
        S_W_CMP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_CLEAR;
          sweep_q <= '1;
        end
      endcase
    end
  end

  // Outputs are forced low while rst is held so a dropped response vanishes at once
  assign query_request_ready  = !rst && (state_q == S_IDLE) && !clear_cache && !clear_pend_q;
  assign write_request_ready  = query_request_ready && !query_request_valid;
  assign query_response_valid = resp_valid_q && !rst;
  assign query_response_error = resp_err_q && !rst;
  assign query_response_mac   = rst ? 48'h0 : resp_mac_q;

endmodule
`default_nettype wire

// File: doc/arp_cache_2way.md
Name: arp_cache_2way

Overview:
- Next-generation ARP cache: 2-way set-associative IP-to-MAC lookup with per-set LRU replacement, in-place update of existing entries, and full valid/ready backpressure on the query response.
- Sits between the ARP frame processor (writes) and the IP transmit path (queries).
- A single internal FSM serialises clear sweeps, queries and writes against one read-before-write RAM.

Parameters:
- CACHE_ADDR_WIDTH, 9, log2 of set count (1..16); total entries = 2 * 2^CACHE_ADDR_WIDTH.
- AGE_WIDTH, 8, width of the timestamp field and of the global timestamp counter (used only with expiry).
- MAX_AGE, 200, age in ticks at which an entry counts as expired (used only with expiry); must be < 2^AGE_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- query_request_valid  in  1  query handshake valid
- query_request_ready  out  1  query handshake ready
- query_request_ip  in  32  IP to look up
- query_response_valid  out  1  response valid, held until accepted
- query_response_ready  in  1  response consumer ready
- query_response_error  out  1  1 = miss
- query_response_mac  out  48  MAC on hit
- write_request_valid  in  1  write handshake valid
- write_request_ready  out  1  write handshake ready
- write_request_ip  in  32  IP to store
- write_request_mac  in  48  MAC to store
- clear_cache  in  1  invalidate all entries
- age_tick  in  1  timestamp advance strobe; ignored without expiry

Behaviour:
- Set index = (ip[15:0] ^ ip[31:16]) truncated to CACHE_ADDR_WIDTH LSBs.
- Set word contents: per way {valid, ip[31:0], mac[47:0], ts[AGE_WIDTH-1:0]}, plus one lru bit naming the way to evict next.
- RAM read latency is 1 cycle; the RAM is inferrable as block RAM.
- FSM states: CLEAR, IDLE, Q_RD, Q_CMP, Q_RESP, W_RD, W_CMP.
- On reset: state = CLEAR, sweep address = all ones. All outputs are 0 during reset, including both ready signals.
- CLEAR: writes an all-zero set word each cycle, address counting down. Entered from 2^A-1 and exits to IDLE after writing set 0, taking 2^CACHE_ADDR_WIDTH cycles. Both ready signals are 0 throughout.
- IDLE priority: pending or asserted clear_cache, then query, then write.
  - query_request_ready = (IDLE && !clear && !clear_pending).
  - write_request_ready = query_request_ready && !query_request_valid.
  - Both ready signals are combinational from state and inputs.
- Query path:
  - Accepted in cycle T; IP and index are latched.
  - Q_RD (T+1): read issued.
  - Q_CMP (T+2): both ways compared.
  - Hit = valid && ip match && not expired.
  - Response registered at the T+3 edge: query_response_valid=1, error=!hit, mac = hit way's MAC (0 on miss).
  - Q_RESP holds valid, error and mac stable until query_response_ready. Return to IDLE on the handshake cycle.
  - Minimum query-to-query spacing is 4 cycles.
  - Hit in way w sets lru <= ~w (written back in Q_CMP). A miss leaves the set unchanged.
  - If both ways match (must not occur), way 0 wins.
- Write path:
  - Accepted in IDLE; ip and mac are latched. W_RD reads the set; W_CMP writes back. Returns to IDLE after 3 cycles total.
  - Target way is chosen in this order:
    1. The way whose valid ip matches (in-place MAC/ts update, way 0 first).
    2. The lowest-index invalid or expired way.
    3. The lru way.
  - The written way gets valid=1 and ts = current timestamp. Then lru <= ~written way.
- clear_cache asserted outside IDLE sets clear_pending. The in-flight operation finishes, including the response handshake, then the FSM enters CLEAR. Pending is cleared on CLEAR entry.
- rst mid-operation: any pending response is dropped (valid deasserts immediately) and the FSM restarts CLEAR.
- A query during CLEAR is stalled, never answered from stale data.

Optional Feature:
- Macro: ARP_CACHE_EXPIRY_EN.
- Defined:
  - A global AGE_WIDTH counter increments on each age_tick cycle, wrapping; reset to 0.
  - An entry is expired when ((now - ts) mod 2^AGE_WIDTH) >= MAX_AGE.
  - Expired entries miss on query and are preferred for replacement.
  - Entries older than 2^AGE_WIDTH ticks may alias as fresh; this is accepted.
- Not defined: ts is not stored, age_tick is ignored, and no entry ever expires.

Test Plan:
- Reset then idle -> both ready signals stay 0 for exactly 512 cycles (A=9), then go to 1. Query 10.0.0.1 -> error=1, mac=0, with valid at T+3.
- Write 192.168.1.10/02:00:00:00:00:0A, then query the same IP -> valid 3 cycles after accept, error=0, mac=0x02000000000A. Hold query_response_ready low 5 cycles -> outputs stable and query_request_ready=0.
- Write three IPs that share set index 0x000 (0x00000000, 0x00010001, 0x00020002) with no intervening queries -> the first entry is evicted: query 0x00000000 misses, the other two hit.
- Write 0x00000000 and 0x00010001 (same set), query 0x00000000 (hit), then write 0x00020002 -> 0x00010001 is evicted, 0x00000000 still hits.
- Rewrite an existing IP with a new MAC -> the query returns the new MAC and the other way's entry survives. Assert clear_cache during Q_RESP -> the response completes, then 512 clear cycles, then all queries miss.
- With ARP_CACHE_EXPIRY_EN, MAX_AGE=4: write an entry, pulse age_tick 3 times -> hit. One more tick -> miss, and a subsequent same-set write reuses that way.
